// File: rtl/sort4_pkg.sv
// Shared types and constants for the four-entry sorting controller.
// Holds the controller states, frame geometry, comparator select codes and the step-to-pair schedule.
package sort4_pkg;

    localparam int DATA_W     = 8;
    localparam int FRAME_LEN  = 4;
    localparam int SORT_STEPS = 6;

    localparam logic [1:0] LAST_IDX  = 2'(FRAME_LEN - 1);
    localparam logic [2:0] LAST_STEP = 3'(SORT_STEPS - 1);
    localparam logic [2:0] SWAP_MAX  = 3'(SORT_STEPS);

    localparam logic [1:0] SEL_GT  = 2'b00;
    localparam logic [1:0] SEL_LT  = 2'b01;
    localparam logic [1:0] SEL_EQ  = 2'b10;
    localparam logic [1:0] SEL_NEQ = 2'b11;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SORT = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Bubble-sort schedule for four entries: each step compares entry i with entry i+1.
    function automatic logic [1:0] pair_index(input logic [2:0] step);
        logic [1:0] i;
        case (step)
            3'd0:    i = 2'd0;
            3'd1:    i = 2'd1;
            3'd2:    i = 2'd2;
            3'd3:    i = 2'd0;
            3'd4:    i = 2'd1;
            3'd5:    i = 2'd0;
            default: i = 2'd0;
        endcase
        return i;
    endfunction

endpackage

// File: rtl/comparator_module.sv
// Unsigned 8-bit comparator. It reports all relations on y[3:0] and the relation picked by sel on y[4].
// y[0]=a<b, y[1]=a>b, y[2]=a==b, y[3]=a!=b; the remaining bits are zero.
module comparator_module
    import sort4_pkg::*;
(
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [1:0]  sel,
    output logic [15:0] y
);

    always_comb begin
        y    = '0;
        y[0] = (a < b);
        y[1] = (a > b);
        y[2] = (a == b);
        y[3] = (a != b);
        case (sel)
            SEL_GT:  y[4] = y[1];
            SEL_LT:  y[4] = y[0];
            SEL_EQ:  y[4] = y[2];
            SEL_NEQ: y[4] = y[3];
            default: y[4] = 1'b0;
        endcase
    end

endmodule

// File: rtl/sort4_ctrl.sv
// Collects a four-beat frame, sorts it in place with six compare-and-swap steps
// on a single shared comparator, then streams the result out under valid/ready.
module sort4_ctrl
    import sort4_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic             ascending,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic             busy,
    output logic [2:0]       swap_cnt
);

    state_t state_q;
    state_t state_d;

    logic [DATA_W-1:0] data_q [FRAME_LEN];
    logic [1:0]        k;
    logic [2:0]        step;
    logic [1:0]        idx;
    logic              ord;

    logic              in_fire;
    logic              out_fire;

    logic [1:0]        pair_i;
    logic [1:0]        pair_j;
    logic [DATA_W-1:0] cmp_a;
    logic [DATA_W-1:0] cmp_b;
    logic [1:0]        cmp_sel;
    logic [15:0]       cmp_y;
    logic              do_swap;
    logic              unused_cmp_bits;

    assign pair_i  = pair_index(step);
    assign pair_j  = pair_i + 2'd1;
    assign cmp_a   = data_q[pair_i];
    assign cmp_b   = data_q[pair_j];
    assign cmp_sel = ord ? SEL_GT : SEL_LT;
    assign do_swap = ord ? cmp_y[1] : cmp_y[0];
    assign unused_cmp_bits = ^cmp_y[15:2];

    comparator_module u_cmp (
        .a   (cmp_a),
        .b   (cmp_b),
        .sel (cmp_sel),
        .y   (cmp_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs decode from state only, so neither handshake input reaches an output combinationally.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        out_data  = '0;
        in_fire   = 1'b0;
        out_fire  = 1'b0;
        case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                in_fire  = in_valid;
                if (in_valid && (k == LAST_IDX)) begin
                    state_d = SORT;
                end
            end
            SORT: begin
                busy = 1'b1;
                if (step == LAST_STEP) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = data_q[idx];
                out_fire  = out_ready;
                if (out_ready && (idx == LAST_IDX)) begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Sort order is captured with the first beat so later changes to ascending cannot affect the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            k        <= '0;
            step     <= '0;
            idx      <= '0;
            swap_cnt <= '0;
            ord      <= 1'b1;
            for (int i = 0; i < FRAME_LEN; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_fire) begin
                        data_q[k] <= in_data;
                        k         <= k + 2'd1;
                        if (k == 2'd0) begin
                            ord <= ascending;
                        end
                        if (k == LAST_IDX) begin
                            step     <= '0;
                            swap_cnt <= '0;
                        end
                    end
                end
                SORT: begin
                    if (do_swap) begin
                        data_q[pair_i] <= cmp_b;
                        data_q[pair_j] <= cmp_a;
                        if (swap_cnt != SWAP_MAX) begin
                            swap_cnt <= swap_cnt + 3'd1;
                        end
                    end
                    if (step == LAST_STEP) begin
                        step <= '0;
                        idx  <= '0;
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                OUT: begin
                    if (out_fire) begin
                        idx <= idx + 2'd1;
                        if (idx == LAST_IDX) begin
                            k <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort4_ctrl.sv
// Directed bench for sort4_ctrl: hand-sorted frames, latency, backpressure, mid-sort reset and order latch.
// Inputs change and outputs are sampled on the falling edge; the design acts on the rising edge.
module tb_sort4_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       ascending;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
    logic [2:0] swap_cnt;

    int checks   = 0;
    int failures = 0;
    int lat;

    always #5 clk = ~clk;

    sort4_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .ascending (ascending),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .swap_cnt  (swap_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Frame bytes are packed first-beat-first in bits [31:24].
    task automatic applyStimulus(input string tag, input logic [31:0] frame, input logic asc0, input logic asc_rest);
        int waited;
        for (int b = 0; b < 4; b++) begin
            in_valid  = 1'b1;
            in_data   = frame[31 - 8*b -: 8];
            ascending = (b == 0) ? asc0 : asc_rest;
            waited = 0;
            while (!in_ready && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            checkOutput({tag, "_beat_ready"}, in_ready, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic waitOutput(input string tag, input logic hold_valid, input logic [7:0] hold_data, output int latency);
        in_valid = hold_valid;
        in_data  = hold_data;
        checkOutput({tag, "_sort_busy"}, busy, 1);
        checkOutput({tag, "_sort_in_ready"}, in_ready, 0);
        latency = 1;
        while (!out_valid && latency < 20) begin
            @(negedge clk);
            latency++;
        end
        checkOutput({tag, "_latency"}, latency, 7);
    endtask

    task automatic drainFrame(input string tag, input logic [31:0] expected, input logic [2:0] eswap, input logic stall);
        if (stall) begin
            out_ready = 1'b0;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                checkOutput({tag, "_stall_valid"}, out_valid, 1);
                checkOutput({tag, "_stall_data"}, out_data, expected[31:24]);
            end
        end
        out_ready = 1'b1;
        checkOutput({tag, "_swap_cnt"}, swap_cnt, eswap);
        for (int b = 0; b < 4; b++) begin
            checkOutput({tag, "_out_valid"}, out_valid, 1);
            checkOutput({tag, "_out_data"}, out_data, expected[31 - 8*b -: 8]);
            checkOutput({tag, "_out_in_ready"}, in_ready, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkOutput({tag, "_ret_in_ready"}, in_ready, 1);
        checkOutput({tag, "_ret_out_valid"}, out_valid, 0);
        checkOutput({tag, "_ret_busy"}, busy, 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        ascending = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_out_data", out_data, 8'h00);
        checkOutput("rst_swap_cnt", swap_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus("asc", 32'h40103020, 1'b1, 1'b1);
        waitOutput("asc", 1'b0, 8'h00, lat);
        drainFrame("asc", 32'h10203040, 3'd4, 1'b0);

        applyStimulus("desc", 32'h0505FF00, 1'b0, 1'b0);
        waitOutput("desc", 1'b0, 8'h00, lat);
        drainFrame("desc", 32'hFF050500, 3'd2, 1'b0);

        applyStimulus("ext", 32'h00FF00FF, 1'b1, 1'b1);
        waitOutput("ext", 1'b0, 8'h00, lat);
        drainFrame("ext", 32'h0000FFFF, 3'd1, 1'b0);

        applyStimulus("rev", 32'h04030201, 1'b1, 1'b1);
        waitOutput("rev", 1'b0, 8'h00, lat);
        drainFrame("rev", 32'h01020304, 3'd6, 1'b0);

        // in_valid stays high with a stray byte through SORT and the stalled OUT phase.
        applyStimulus("bp", 32'h7F012080, 1'b1, 1'b1);
        waitOutput("bp", 1'b1, 8'hAA, lat);
        drainFrame("bp", 32'h01207F80, 3'd2, 1'b1);

        applyStimulus("abort", 32'h11223344, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_in_ready", in_ready, 1);
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_swap_cnt", swap_cnt, 0);
        applyStimulus("fresh", 32'h03010200, 1'b1, 1'b1);
        waitOutput("fresh", 1'b0, 8'h00, lat);
        drainFrame("fresh", 32'h00010203, 3'd5, 1'b0);

        applyStimulus("latch", 32'h30102000, 1'b1, 1'b0);
        waitOutput("latch", 1'b0, 8'h00, lat);
        drainFrame("latch", 32'h00102030, 3'd5, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sort4_ctrl.md
SORT4_CTRL -- requirements
Module: sort4_ctrl

Interface
REQ-001 Parameters: none; data width fixed at 8 bits, frame length fixed at 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  in_data holds a valid beat.
REQ-005 in_ready  output  1  block accepts a beat this cycle.
REQ-006 in_data  input  8  unsigned input value.
REQ-007 ascending  input  1  sort order: 1 = ascending, 0 = descending; sampled only on the first beat of a frame.
REQ-008 out_valid  output  1  out_data holds a valid sorted beat.
REQ-009 out_ready  input  1  downstream accepts the beat.
REQ-010 out_data  output  8  sorted value.
REQ-011 busy  output  1  high in SORT and OUT states.
REQ-012 swap_cnt  output  3  number of swaps performed in the last sort; valid in OUT.

Function
REQ-013 States: LOAD, SORT, OUT; handshake completes on valid && ready.
REQ-014 LOAD: in_ready=1, out_valid=0; each accepted beat is written to reg[k], k = 0..3; the beat accepted at k=0 also latches ascending into ord.
REQ-015 The accept of the 4th beat (k=3) moves state to SORT with step=0 and swap_cnt=0; in_ready=0 in SORT and OUT.
REQ-016 SORT runs exactly 6 cycles, one compare-and-swap per cycle, on fixed pairs by step 0..5: (0,1),(1,2),(2,3),(0,1),(1,2),(0,1).
REQ-017 Each step drives the shared comparator with A=reg[i], B=reg[i+1].
REQ-018 Comparator select: 2'b00 (gt) when ord=1, 2'b01 (lt) when ord=0.
REQ-019 Swap condition: Y[1] (A>B) when ord=1, Y[0] (A<B) when ord=0; equal values are never swapped.
REQ-020 On a swap, reg[i] and reg[i+1] exchange at the clock edge and swap_cnt increments; swap_cnt saturates at its maximum of 6.
REQ-021 After step 5, state moves to OUT with idx=0.
REQ-022 Latency: if the 4th input beat is accepted in cycle t, out_valid is first high in cycle t+7.
REQ-023 OUT: out_valid=1, out_data=reg[idx]; idx advances on each handshake.
REQ-024 out_data is held stable while out_ready=0.
REQ-025 The handshake at idx=3 returns the block to LOAD with k=0; in_ready is high in the next cycle.
REQ-026 in_valid in SORT/OUT is ignored and no data is lost; upstream holds the beat until in_ready is high.
REQ-027 ascending changes after the first beat of a frame have no effect on that frame.
REQ-028 No output depends combinationally on in_valid or out_ready.

Reset
REQ-029 rst=1 at a clock edge forces state=LOAD, k=0, step=0, idx=0, swap_cnt=0 and ord=1.
REQ-030 Outputs after reset: in_ready=1, out_valid=0, busy=0, out_data=8'h00.
REQ-031 Reset in any state, including mid-SORT or mid-OUT, discards the partial frame.
REQ-032 reg[0..3] are cleared to 8'h00 on reset.

Structure
REQ-033 Package sort4_pkg holds:
- state enum (LOAD, SORT, OUT);
- constants FRAME_LEN=4 and SORT_STEPS=6;
- comparator select codes SEL_GT=2'b00, SEL_LT=2'b01, SEL_EQ=2'b10, SEL_NEQ=2'b11;
- the step-to-pair-index lookup.
REQ-034 Exactly one instance of the existing comparator_module (8-bit A/B, 2-bit select, 16-bit Y) is shared across all steps; no other magnitude comparison logic exists in the block.

Verification
REQ-035 Ascending sort: frame 8'h40, 8'h10, 8'h30, 8'h20 with ascending=1 -> outputs 10, 20, 30, 40; out_valid first high exactly 7 cycles after the 4th accept; swap_cnt=4.
REQ-036 Descending with duplicates: frame 05, 05, FF, 00 with ascending=0 -> outputs FF, 05, 05, 00; swap_cnt=2.
REQ-037 Extremes and worst case:
- frame 00, FF, 00, FF ascending -> 00, 00, FF, FF;
- reversed frame 04, 03, 02, 01 ascending -> 01, 02, 03, 04 with swap_cnt=6.
REQ-038 Backpressure: hold out_ready=0 for 5 cycles in OUT -> out_data is stable and idx is unchanged; in_valid held high during SORT/OUT is not accepted.
REQ-039 Reset mid-operation: assert rst at SORT step 3 -> next cycle in_ready=1, out_valid=0, busy=0; a fresh frame 03, 01, 02, 00 ascending then sorts to 00, 01, 02, 03.
REQ-040 Order latch: ascending=1 on beat 0, toggled to 0 on beats 1-3 -> frame is sorted ascending.
